// File: rtl/reg_file_pkg.sv
// Shared defaults and address-compare helper for the register file and its scoreboard.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ADDR_MAX_W = 16;

  // Callers zero-extend their addresses to ADDR_MAX_W so one helper serves any ADDR_W.
  function automatic logic addr_hit(input logic [ADDR_MAX_W-1:0] a,
                                    input logic [ADDR_MAX_W-1:0] b,
                                    input logic                  en);
    return en && (a == b);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: busy bit per register, reservation acknowledge, flush, busy count.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter bit ZERO_R0 = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [ADDR_W-1:0]       wr_addr_i,
  input  logic                    rsv_en_i,
  input  logic [ADDR_W-1:0]       rsv_addr_i,
  input  logic                    flush_i,
  output logic                    rsv_ack_o,
  output logic [(2**ADDR_W)-1:0]  busy_o,
  output logic [ADDR_W:0]         busy_cnt_o
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;
  logic             wr_rsv_hit, rsv_zero, set_busy, clr_busy;

  always_comb begin
    wr_rsv_hit = addr_hit(ADDR_MAX_W'(wr_addr_i), ADDR_MAX_W'(rsv_addr_i), wr_en_i);
    rsv_zero   = ZERO_R0 && (rsv_addr_i == '0);
    // A write retiring the same register frees it in time for the new reservation.
    rsv_ack_o  = rsv_en_i && !flush_i && (!busy_q[rsv_addr_i] || wr_rsv_hit);
    set_busy   = rsv_ack_o && !rsv_zero && !busy_q[rsv_addr_i];
    clr_busy   = wr_en_i && busy_q[wr_addr_i] && !(rsv_ack_o && wr_rsv_hit);

    busy_d = busy_q;
    if (wr_en_i) busy_d[wr_addr_i] = 1'b0;
    if (rsv_ack_o && !rsv_zero) busy_d[rsv_addr_i] = 1'b1;
    cnt_d = cnt_q + {ADDR_W'(0), set_busy} - {ADDR_W'(0), clr_busy};

    if (flush_i) begin
      busy_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign busy_o     = busy_q;
  assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with write-to-read bypass and an integrated pending-write scoreboard.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int NUM_RD  = 2,
  parameter bit ZERO_R0 = 1'b1,
  parameter bit BYPASS  = 1'b1
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NUM_RD*ADDR_W-1:0] RD_ADDR,
  output logic [NUM_RD*DATA_W-1:0] RD_DATA,
  output logic [NUM_RD-1:0]        RD_BUSY,
  input  logic                     WR_EN,
  input  logic [ADDR_W-1:0]        WR_ADDR,
  input  logic [DATA_W-1:0]        WR_DATA,
  input  logic                     RSV_EN,
  input  logic [ADDR_W-1:0]        RSV_ADDR,
  output logic                     RSV_ACK,
  input  logic                     FLUSH,
  output logic [ADDR_W:0]          BUSY_CNT
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0]  busy_vec;
  logic              wr_lands;

  assign wr_lands = WR_EN && !(ZERO_R0 && (WR_ADDR == '0));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_lands) begin
      regs_q[WR_ADDR] <= WR_DATA;
    end
  end

  reg_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_sb (
    .clk_i      (CLK),
    .rst_i      (RESET),
    .wr_en_i    (WR_EN),
    .wr_addr_i  (WR_ADDR),
    .rsv_en_i   (RSV_EN),
    .rsv_addr_i (RSV_ADDR),
    .flush_i    (FLUSH),
    .rsv_ack_o  (RSV_ACK),
    .busy_o     (busy_vec),
    .busy_cnt_o (BUSY_CNT)
  );

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit, zero;

    assign ra   = RD_ADDR[k*ADDR_W +: ADDR_W];
    assign hit  = BYPASS && addr_hit(ADDR_MAX_W'(WR_ADDR), ADDR_MAX_W'(ra), WR_EN);
    assign zero = ZERO_R0 && (ra == '0);

    // A write landing this cycle both forwards its data and retires the reservation the reader sees.
    assign RD_DATA[k*DATA_W +: DATA_W] = zero ? '0 : (hit ? WR_DATA : regs_q[ra]);
    assign RD_BUSY[k] = !zero && busy_vec[ra] && !hit;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: two configurations (bypass/zero-r0 with 2 ports, plain with 4 ports) against a reference model.
module tb_reg_file_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;
  localparam int NA = 2;
  localparam int NB = 4;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RESET, WR_EN, RSV_EN, FLUSH;
  logic [AW-1:0] WR_ADDR, RSV_ADDR;
  logic [DW-1:0] WR_DATA;

  logic [NA*AW-1:0] rd_addr_a;
  logic [NA*DW-1:0] rd_data_a;
  logic [NA-1:0]    rd_busy_a;
  logic             ack_a;
  logic [AW:0]      cnt_a;

  logic [NB*AW-1:0] rd_addr_b;
  logic [NB*DW-1:0] rd_data_b;
  logic [NB-1:0]    rd_busy_b;
  logic             ack_b;
  logic [AW:0]      cnt_b;

  int n_chk = 0;
  int n_fail = 0;

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NA), .ZERO_R0(1'b1), .BYPASS(1'b1)) dut_a (
    .CLK(CLK), .RESET(RESET), .RD_ADDR(rd_addr_a), .RD_DATA(rd_data_a), .RD_BUSY(rd_busy_a),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .RSV_EN(RSV_EN), .RSV_ADDR(RSV_ADDR),
    .RSV_ACK(ack_a), .FLUSH(FLUSH), .BUSY_CNT(cnt_a));

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NB), .ZERO_R0(1'b0), .BYPASS(1'b0)) dut_b (
    .CLK(CLK), .RESET(RESET), .RD_ADDR(rd_addr_b), .RD_DATA(rd_data_b), .RD_BUSY(rd_busy_b),
    .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .RSV_EN(RSV_EN), .RSV_ADDR(RSV_ADDR),
    .RSV_ACK(ack_b), .FLUSH(FLUSH), .BUSY_CNT(cnt_b));

  // Reference model: variant 0 = zero-r0 + bypass, variant 1 = ordinary r0, no bypass.
  logic [DW-1:0] m_reg  [2][DEPTH];
  bit            m_busy [2][DEPTH];

  function automatic logic [DW-1:0] exp_data(input int v, input logic [AW-1:0] ra);
    if (v == 0 && ra == 0) return '0;
    if (v == 0 && WR_EN && WR_ADDR == ra) return WR_DATA;
    return m_reg[v][ra];
  endfunction

  function automatic bit exp_busy(input int v, input logic [AW-1:0] ra);
    if (v == 0 && ra == 0) return 1'b0;
    if (v == 0 && WR_EN && WR_ADDR == ra) return 1'b0;
    return m_busy[v][ra];
  endfunction

  function automatic bit exp_ack(input int v);
    return RSV_EN && !FLUSH && (!m_busy[v][RSV_ADDR] || (WR_EN && WR_ADDR == RSV_ADDR));
  endfunction

  function automatic logic [AW:0] exp_cnt(input int v);
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_busy[v][i]);
    return (AW+1)'(c);
  endfunction

  task automatic model_step();
    bit ack;
    for (int v = 0; v < 2; v++) begin
      if (RESET) begin
        for (int i = 0; i < DEPTH; i++) begin
          m_reg[v][i]  = '0;
          m_busy[v][i] = 1'b0;
        end
      end else begin
        ack = exp_ack(v);
        if (WR_EN && !(v == 0 && WR_ADDR == 0)) m_reg[v][WR_ADDR] = WR_DATA;
        if (WR_EN) m_busy[v][WR_ADDR] = 1'b0;
        if (ack && !(v == 0 && RSV_ADDR == 0)) m_busy[v][RSV_ADDR] = 1'b1;
        if (FLUSH) for (int i = 0; i < DEPTH; i++) m_busy[v][i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic idle();
    RESET = 1'b0; WR_EN = 1'b0; RSV_EN = 1'b0; FLUSH = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [AW-1:0] a2, input logic [AW-1:0] a3);
    rd_addr_a = {a1, a0};
    rd_addr_b = {a3, a2, a1, a0};
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom);
    return AW'($urandom_range(0, 7));
  endfunction

  task automatic test_reset();
    RESET = 1'b1; WR_EN = 1'b0; RSV_EN = 1'b0; FLUSH = 1'b0;
    tick(); tick();
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      set_rd(AW'(a), AW'(a), AW'(a), AW'(a));
      #1;
      for (int k = 0; k < NA; k++) begin
        n_chk++;
        if (rd_data_a[k*DW +: DW] !== '0 || rd_busy_a[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_a addr%0d port%0d: data %h busy %b, want 0 0", a, k, rd_data_a[k*DW +: DW], rd_busy_a[k]);
        end
      end
      for (int k = 0; k < NB; k++) begin
        n_chk++;
        if (rd_data_b[k*DW +: DW] !== '0 || rd_busy_b[k] !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_b addr%0d port%0d: data %h busy %b, want 0 0", a, k, rd_data_b[k*DW +: DW], rd_busy_b[k]);
        end
      end
      n_chk++;
      if (cnt_a !== '0 || cnt_b !== '0) begin
        n_fail++;
        $display("FAIL reset_cnt: a=%0d b=%0d, want 0 0", cnt_a, cnt_b);
      end
      tick();
    end
  endtask

  task automatic test_bypass();
    idle();
    WR_EN = 1'b1; WR_ADDR = 5'd5; WR_DATA = 32'hDEADBEEF;
    set_rd(5'd5, 5'd5, 5'd5, 5'd5);
    #1;
    n_chk++;
    if (rd_data_a[DW-1:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL bypass_a: got %h want deadbeef", rd_data_a[DW-1:0]);
    end
    n_chk++;
    if (rd_data_b[DW-1:0] !== 32'h0) begin
      n_fail++; $display("FAIL nobypass_b: got %h want 00000000", rd_data_b[DW-1:0]);
    end
    tick(); idle(); #1;
    n_chk++;
    if (rd_data_a[DW-1:0] !== 32'hDEADBEEF || rd_data_b[DW-1:0] !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL write_lands: a=%h b=%h want deadbeef", rd_data_a[DW-1:0], rd_data_b[DW-1:0]);
    end
  endtask

  task automatic test_zero_reg();
    idle();
    WR_EN = 1'b1; WR_ADDR = 5'd0; WR_DATA = 32'h1234;
    RSV_EN = 1'b1; RSV_ADDR = 5'd0;
    set_rd(5'd0, 5'd0, 5'd0, 5'd0);
    #1;
    n_chk++;
    if (rd_data_a[DW-1:0] !== '0 || ack_a !== 1'b1 || ack_b !== 1'b1) begin
      n_fail++; $display("FAIL zero_same_cycle: data_a %h ack_a %b ack_b %b, want 0 1 1", rd_data_a[DW-1:0], ack_a, ack_b);
    end
    tick(); idle(); #1;
    n_chk++;
    if (rd_data_a[DW-1:0] !== '0 || cnt_a !== '0 || rd_busy_a[0] !== 1'b0) begin
      n_fail++; $display("FAIL zero_a: data %h cnt %0d busy %b, want 0 0 0", rd_data_a[DW-1:0], cnt_a, rd_busy_a[0]);
    end
    n_chk++;
    if (rd_data_b[DW-1:0] !== 32'h1234 || cnt_b !== 6'd1 || rd_busy_b[0] !== 1'b1) begin
      n_fail++; $display("FAIL plain_r0_b: data %h cnt %0d busy %b, want 1234 1 1", rd_data_b[DW-1:0], cnt_b, rd_busy_b[0]);
    end
    WR_EN = 1'b1; WR_ADDR = 5'd0; WR_DATA = 32'h0;
    tick(); idle();
  endtask

  task automatic test_waw();
    idle();
    RSV_EN = 1'b1; RSV_ADDR = 5'd7;
    set_rd(5'd7, 5'd7, 5'd7, 5'd7);
    #1;
    n_chk++;
    if (ack_a !== 1'b1) begin n_fail++; $display("FAIL waw_first_ack: got %b want 1", ack_a); end
    tick(); #1;
    n_chk++;
    if (cnt_a !== 6'd1 || ack_a !== 1'b0 || ack_b !== 1'b0 || rd_busy_a[0] !== 1'b1) begin
      n_fail++; $display("FAIL waw_stall: cnt %0d ack_a %b ack_b %b busy %b, want 1 0 0 1", cnt_a, ack_a, ack_b, rd_busy_a[0]);
    end
    tick();
    WR_EN = 1'b1; WR_ADDR = 5'd7; WR_DATA = 32'h777;
    #1;
    n_chk++;
    if (ack_a !== 1'b1 || rd_busy_a[0] !== 1'b0 || rd_busy_b[0] !== 1'b1) begin
      n_fail++; $display("FAIL waw_wr_rsv: ack %b busy_a %b busy_b %b, want 1 0 1", ack_a, rd_busy_a[0], rd_busy_b[0]);
    end
    tick(); idle(); #1;
    n_chk++;
    if (cnt_a !== 6'd1 || cnt_b !== 6'd1 || rd_busy_a[0] !== 1'b1 || rd_data_a[DW-1:0] !== 32'h777) begin
      n_fail++; $display("FAIL waw_after: cnt %0d/%0d busy %b data %h, want 1/1 1 777", cnt_a, cnt_b, rd_busy_a[0], rd_data_a[DW-1:0]);
    end
    WR_EN = 1'b1; WR_ADDR = 5'd7; WR_DATA = 32'h778;
    tick(); idle(); #1;
    n_chk++;
    if (cnt_a !== '0 || cnt_b !== '0) begin
      n_fail++; $display("FAIL waw_retire: cnt %0d/%0d want 0/0", cnt_a, cnt_b);
    end
  endtask

  task automatic test_flush();
    logic [AW-1:0] rs [3] = '{5'd3, 5'd4, 5'd9};
    idle();
    for (int i = 0; i < 3; i++) begin
      RSV_EN = 1'b1; RSV_ADDR = rs[i];
      tick();
    end
    idle(); #1;
    n_chk++;
    if (cnt_a !== 6'd3 || cnt_b !== 6'd3) begin
      n_fail++; $display("FAIL flush_pre_cnt: %0d/%0d want 3/3", cnt_a, cnt_b);
    end
    FLUSH = 1'b1; WR_EN = 1'b1; WR_ADDR = 5'd4; WR_DATA = 32'h55;
    RSV_EN = 1'b1; RSV_ADDR = 5'd10;
    set_rd(5'd4, 5'd3, 5'd9, 5'd10);
    #1;
    n_chk++;
    if (ack_a !== 1'b0 || ack_b !== 1'b0) begin
      n_fail++; $display("FAIL flush_ack: %b/%b want 0/0", ack_a, ack_b);
    end
    tick(); idle(); #1;
    n_chk++;
    if (cnt_a !== '0 || cnt_b !== '0 || rd_busy_a !== '0 || rd_busy_b !== '0) begin
      n_fail++; $display("FAIL flush_clear: cnt %0d/%0d busy %b/%b want 0", cnt_a, cnt_b, rd_busy_a, rd_busy_b);
    end
    n_chk++;
    if (rd_data_a[DW-1:0] !== 32'h55 || rd_data_b[DW-1:0] !== 32'h55) begin
      n_fail++; $display("FAIL flush_write: %h/%h want 55", rd_data_a[DW-1:0], rd_data_b[DW-1:0]);
    end
  endtask

  task automatic test_reset_mid();
    idle();
    RSV_EN = 1'b1; RSV_ADDR = 5'd2; WR_EN = 1'b1; WR_ADDR = 5'd2; WR_DATA = 32'h77;
    tick();
    WR_EN = 1'b0; RSV_ADDR = 5'd6;
    tick(); idle();
    set_rd(5'd2, 5'd6, 5'd4, 5'd2);
    #1;
    n_chk++;
    if (cnt_a !== 6'd2 || rd_data_a[DW-1:0] !== 32'h77 || rd_busy_a !== 2'b11) begin
      n_fail++; $display("FAIL rstmid_pre: cnt %0d data %h busy %b want 2 77 11", cnt_a, rd_data_a[DW-1:0], rd_busy_a);
    end
    RESET = 1'b1; WR_EN = 1'b1; WR_ADDR = 5'd2; WR_DATA = 32'h99; RSV_EN = 1'b1; RSV_ADDR = 5'd11;
    tick(); idle(); #1;
    n_chk++;
    if (cnt_a !== '0 || cnt_b !== '0 || rd_busy_a !== '0 || rd_busy_b !== '0) begin
      n_fail++; $display("FAIL rstmid_busy: cnt %0d/%0d busy %b/%b want 0", cnt_a, cnt_b, rd_busy_a, rd_busy_b);
    end
    n_chk++;
    if (rd_data_a !== '0 || rd_data_b !== '0) begin
      n_fail++; $display("FAIL rstmid_data: a=%h b=%h want 0", rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_random(input int n);
    logic [AW-1:0] ra [NB];
    for (int i = 0; i < n; i++) begin
      RESET    = ($urandom_range(0, 63) == 0);
      FLUSH    = ($urandom_range(0, 15) == 0);
      WR_EN    = 1'($urandom_range(0, 1));
      WR_ADDR  = rnd_addr();
      WR_DATA  = $urandom;
      RSV_EN   = 1'($urandom_range(0, 1));
      RSV_ADDR = ($urandom_range(0, 3) == 0) ? WR_ADDR : rnd_addr();
      for (int k = 0; k < NB; k++) ra[k] = ($urandom_range(0, 2) == 0) ? WR_ADDR : rnd_addr();
      set_rd(ra[0], ra[1], ra[2], ra[3]);
      #1;
      for (int k = 0; k < NA; k++) begin
        n_chk++;
        if (rd_data_a[k*DW +: DW] !== exp_data(0, ra[k]) || rd_busy_a[k] !== exp_busy(0, ra[k])) begin
          n_fail++;
          $display("FAIL rand_a cyc%0d port%0d addr%0d: data %h busy %b, want %h %b", i, k, ra[k],
                   rd_data_a[k*DW +: DW], rd_busy_a[k], exp_data(0, ra[k]), exp_busy(0, ra[k]));
        end
      end
      for (int k = 0; k < NB; k++) begin
        n_chk++;
        if (rd_data_b[k*DW +: DW] !== exp_data(1, ra[k]) || rd_busy_b[k] !== exp_busy(1, ra[k])) begin
          n_fail++;
          $display("FAIL rand_b cyc%0d port%0d addr%0d: data %h busy %b, want %h %b", i, k, ra[k],
                   rd_data_b[k*DW +: DW], rd_busy_b[k], exp_data(1, ra[k]), exp_busy(1, ra[k]));
        end
      end
      n_chk++;
      if (ack_a !== exp_ack(0) || ack_b !== exp_ack(1)) begin
        n_fail++; $display("FAIL rand_ack cyc%0d: %b/%b want %b/%b", i, ack_a, ack_b, exp_ack(0), exp_ack(1));
      end
      n_chk++;
      if (cnt_a !== exp_cnt(0) || cnt_b !== exp_cnt(1)) begin
        n_fail++; $display("FAIL rand_cnt cyc%0d: %0d/%0d want %0d/%0d", i, cnt_a, cnt_b, exp_cnt(0), exp_cnt(1));
      end
      tick();
    end
    idle();
  endtask

  initial begin
    RESET = 1'b1; WR_EN = 1'b0; RSV_EN = 1'b0; FLUSH = 1'b0;
    WR_ADDR = '0; WR_DATA = '0; RSV_ADDR = '0;
    rd_addr_a = '0; rd_addr_b = '0;
    @(negedge CLK);
    test_reset();
    test_bypass();
    test_zero_reg();
    test_waw();
    test_flush();
    test_reset_mid();
    test_random(3000);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
